countdown_controller: RTL
=========================

// Module: countdown_controller
// PURPOSE
//   Sequences the countdown-timer datapath of the digital clock: loads a preset
//   in seconds, runs, pauses, decrements on the 1 Hz tick, and raises a timed
//   alarm at zero. Sits between the debounced key pulses, the 1 Hz divider and
//   the display/buzzer logic. Seconds-to-HH:MM:SS conversion is done downstream.
// PARAMETERS
//   W          17   width of preset/remaining-seconds count
//   ALARM_SECS 10   ticks the alarm stays active before auto-return to IDLE
// PORTS
//   clk          in   1  system clock
//   rst          in   1  asynchronous reset, active-high
//   init         in   W  preset value in seconds, sampled only when init_en=1
//   init_en      in   1  one-clk load pulse
//   clear        in   1  one-clk abort pulse
//   toggle_press in   1  one-clk start/stop/acknowledge pulse (pre-debounced)
//   onehz        in   1  one-clk tick, once per second
//   remain       out  W  remaining seconds (registered)
//   running      out  1  1 in RUN
//   done         out  1  one-clk pulse on the cycle ALARM is entered
//   beep         out  1  buzzer enable
//   state        out  3  IDLE=0 LOADED=1 RUN=2 PAUSE=3 ALARM=4
// BEHAVIOUR
//   - Reset (async): state=IDLE, remain=0, running=0, done=0, beep=0, alarm cnt=0.
//   - All outputs registered; every event takes effect on the next clk edge.
//   - Per-cycle priority: clear > init_en > toggle_press > onehz.
//   - clear (any state): -> IDLE, remain=0.
//   - init_en (any state): remain<=init; -> LOADED if init!=0, else IDLE.
//   - IDLE: toggle_press ignored; onehz ignored.
//   - LOADED: toggle_press -> RUN (no decrement that cycle even if onehz=1).
//   - RUN: onehz with remain>1 -> remain-1; onehz with remain==1 -> remain=0,
//     -> ALARM, done=1 for that one cycle. toggle_press -> PAUSE, tick dropped.
//   - PAUSE: remain frozen; toggle_press -> RUN; onehz ignored.
//   - ALARM: alarm cnt cleared on entry, +1 per onehz; on the tick where
//     cnt==ALARM_SECS-1 -> IDLE. toggle_press -> IDLE (acknowledge).
//   - remain never decrements below 0 (no wrap); RUN is never entered with 0.
//   - init_en with toggle_press same cycle: load wins, stays LOADED.
//   - beep=0 outside ALARM, forced 0 on leaving ALARM the same edge.
//   - running = (state==RUN); state encoding fixed as listed above.
// CONFIGURATION
//   COUNTDOWN_BEEP_PULSE_EN defined: beep starts at 1 on ALARM entry and
//     toggles on every onehz while in ALARM (0.5 Hz on/off pattern).
//   Not defined: beep held steady 1 for the whole ALARM state.
//   Both builds: ALARM duration, done pulse and transitions identical.
// TESTING
//   1 init=3,init_en; toggle; 3 ticks -> remain 3,2,1,0; done 1 clk at 3rd
//     tick; state=4; beep=1.
//   2 init=5, run, 2 ticks, toggle -> PAUSE remain=3; 4 ticks -> remain=3;
//     toggle, tick -> remain=2.
//   3 ALARM, 10 ticks, no key -> IDLE after 10th tick, beep=0; with
//     COUNTDOWN_BEEP_PULSE_EN beep sequence 1,0,1,0... per tick.
//   4 init=0,init_en then toggle -> state stays IDLE, running=0, remain=0.
//   5 RUN remain=7: init_en(init=20)+toggle+onehz same clk -> LOADED,
//     remain=20; clear+init_en same clk -> IDLE remain=0.
//   6 rst asserted mid-RUN between edges -> outputs zero immediately, IDLE;
//     after release, toggle ignored until a new load.

Source files
------------

// File: rtl/countdown_controller.sv
// Countdown-timer sequencer: load, run, pause, 1 Hz decrement, timed alarm. States IDLE=0 LOADED=1 RUN=2 PAUSE=3 ALARM=4.
// Build option COUNTDOWN_BEEP_PULSE_EN: beep toggles per tick in ALARM (pulsed), otherwise beep held steady.
module countdown_controller #(
    parameter int W          = 17,
    parameter int ALARM_SECS = 10
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_init,
    input  logic         i_init_en,
    input  logic         i_clear,
    input  logic         i_toggle_press,
    input  logic         i_onehz,
    output logic [W-1:0] o_remain,
    output logic         o_running,
    output logic         o_done,
    output logic         o_beep,
    output logic [2:0]   o_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOADED = 3'd1,
        RUN    = 3'd2,
        PAUSE  = 3'd3,
        ALARM  = 3'd4
    } state_t;

    localparam int CW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ALARM_SECS - 1);

    state_t          r_state;
    logic [W-1:0]    r_remain;
    logic            r_running;
    logic            r_done;
    logic            r_beep;
    logic [CW-1:0]   r_alarm_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_remain    <= '0;
            r_running   <= 1'b0;
            r_done      <= 1'b0;
            r_beep      <= 1'b0;
            r_alarm_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_clear) begin
                r_state     <= IDLE;
                r_remain    <= '0;
                r_running   <= 1'b0;
                r_beep      <= 1'b0;
                r_alarm_cnt <= '0;
            end else if (i_init_en) begin
                r_remain    <= i_init;
                r_state     <= (i_init != '0) ? LOADED : IDLE;
                r_running   <= 1'b0;
                r_beep      <= 1'b0;
                r_alarm_cnt <= '0;
            end else begin
                case (r_state)
                    LOADED: begin
                        if (i_toggle_press) begin
                            r_state   <= RUN;
                            r_running <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (i_toggle_press) begin
                            r_state   <= PAUSE;
                            r_running <= 1'b0;
                        end else if (i_onehz) begin
                            if (r_remain > W'(1)) begin
                                r_remain <= r_remain - W'(1);
                            end else begin
                                // Last second expired: saturate at zero and sound the alarm.
                                r_remain    <= '0;
                                r_state     <= ALARM;
                                r_running   <= 1'b0;
                                r_done      <= 1'b1;
                                r_beep      <= 1'b1;
                                r_alarm_cnt <= '0;
                            end
                        end
                    end
                    PAUSE: begin
                        if (i_toggle_press) begin
                            r_state   <= RUN;
                            r_running <= 1'b1;
                        end
                    end
                    ALARM: begin
                        if (i_toggle_press) begin
                            r_state     <= IDLE;
                            r_beep      <= 1'b0;
                            r_alarm_cnt <= '0;
                        end else if (i_onehz) begin
                            if (r_alarm_cnt == CNT_LAST) begin
                                r_state     <= IDLE;
                                r_beep      <= 1'b0;
                                r_alarm_cnt <= '0;
                            end else begin
                                r_alarm_cnt <= r_alarm_cnt + CW'(1);
`ifdef COUNTDOWN_BEEP_PULSE_EN
                                r_beep      <= ~r_beep;
`else
                                r_beep      <= 1'b1;
`endif
                            end
                        end
                    end
                    default: begin
                        r_state   <= IDLE;
                        r_running <= 1'b0;
                        r_beep    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_remain  = r_remain;
    assign o_running = r_running;
    assign o_done    = r_done;
    assign o_beep    = r_beep;
    assign o_state   = r_state;

endmodule
